// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched -- butterfly scheduler for the fgyrus radix-2 in-place DIT FFT.
//
// Walks log2(N) stages and issues N/2 butterflies per stage. Each butterfly
// carries a cache address pair and a twiddle index. Before the next stage
// starts, every in-flight butterfly of the current stage must be written
// back, because the next stage reads those results (read-after-write hazard).
//
// Optional feature: define FFT_BFLY_SCHED_CYC_CNT_EN to build the busy-cycle
// counter on cyc_cnt. Without it, cyc_cnt is tied to zero.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          1-cycle pulse, begins an FFT (ignored while busy)
//   abort          sync abort, wins over every other input
//   issue_valid    butterfly request valid     issue_rdy   datapath accepts it
//   addr_a/addr_b  cache addresses of upper/lower sample
//   twdl_addr      twiddle RAM index (N/2-entry table)
//   stage          current stage 0..ADDR_W-1
//   wb_ack         one pulse per butterfly written back
//   busy, done     state != IDLE; 1-cycle completion pulse
//   err_underflw   sticky: wb_ack with nothing outstanding
//   cyc_cnt        busy cycles of the last/current run
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | presenting butterfly k of the current stage
// DRAIN | waiting for the outstanding write-backs of this stage
// DONE  | one-cycle done pulse
module fft_bfly_sched #(
    parameter int NUM_SAMPLES = 128,
    parameter int ADDR_W      = 7,
    parameter int STG_W       = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              issue_valid,
    input  logic              issue_rdy,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-2:0] twdl_addr,
    output logic [STG_W-1:0]  stage,
    input  logic              wb_ack,
    output logic              busy,
    output logic              done,
    output logic              err_underflw,
    output logic [CNT_W-1:0]  cyc_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-2:0] K_LAST   = (ADDR_W-1)'(NUM_SAMPLES/2 - 1);
    localparam logic [STG_W-1:0]  STG_LAST = STG_W'(ADDR_W-1);

    state_t            state_q, state_d;
    logic [ADDR_W-2:0] k_q, k_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic [ADDR_W-1:0] os_q, os_d;
    logic              err_q;
    logic              accept, underflow;

    assign accept    = (state_q == S_ISSUE) && issue_rdy;
    assign underflow = wb_ack && ((os_q == '0) || (state_q == S_IDLE));

    // Outstanding count; an ack with nothing in flight leaves it at zero.
    always_comb begin
        os_d = os_q;
        if (accept && !wb_ack)
            os_d = os_q + ADDR_W'(1);
        else if (!accept && wb_ack && (os_q != '0))
            os_d = os_q - ADDR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stg_d   = stg_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    stg_d   = '0;
                end
            end
            S_ISSUE: begin
                if (issue_rdy) begin
                    k_d = k_q + (ADDR_W-1)'(1);   // wraps to 0 after the last butterfly
                    if (k_q == K_LAST)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (os_d == '0) begin
                    if (stg_q == STG_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stg_d   = stg_q + STG_W'(1);
                        k_d     = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stg_d   = '0;
                k_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            stg_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            stg_q   <= '0;
            os_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stg_q   <= stg_d;
            os_q    <= abort ? '0 : os_d;
            // Abort freezes the error flag; a same-cycle underflow beats the start clear.
            if (!abort) begin
                if (underflow)
                    err_q <= 1'b1;
                else if ((state_q == S_IDLE) && start)
                    err_q <= 1'b0;
            end
        end
    end

    // Address decode. Bits of k below the stage position stay in place, and
    // the bits above it move up by one to open the gap selected by 'half'.
    logic [ADDR_W-1:0] kx, half, mask, a_raw;
    logic [ADDR_W-2:0] tw_raw;
    logic [STG_W-1:0]  tw_sh;

    always_comb begin
        kx     = {1'b0, k_q};
        half   = ADDR_W'(1) << stg_q;
        mask   = half - ADDR_W'(1);
        a_raw  = ((kx & ~mask) << 1) | (kx & mask);
        tw_sh  = STG_LAST - stg_q;
        tw_raw = (k_q & mask[ADDR_W-2:0]) << tw_sh;
    end

    assign issue_valid  = (state_q == S_ISSUE);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign stage        = stg_q;
    assign err_underflw = err_q;
    // Address outputs are forced to zero outside ISSUE, so every output reads 0 in reset.
    assign addr_a       = issue_valid ? a_raw : '0;
    assign addr_b       = issue_valid ? (a_raw + half) : '0;
    assign twdl_addr    = issue_valid ? tw_raw : '0;

`ifdef FFT_BFLY_SCHED_CYC_CNT_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc_q <= '0;
        else if ((state_q == S_IDLE) && start && !abort)
            cyc_q <= '0;
        else if (busy && (cyc_q != '1))
            cyc_q <= cyc_q + CNT_W'(1);
    end

    assign cyc_cnt = cyc_q;
`else
    assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed testbench for fft_bfly_sched with N=8 (3 stages, 4 butterflies per stage).
module tb_fft_bfly_sched;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, issue_rdy, wb_ack;
    logic       issue_valid, busy, done, err_underflw;
    logic [2:0] addr_a, addr_b;
    logic [1:0] twdl_addr, stage;
    logic [15:0] cyc_cnt;

    fft_bfly_sched #(.NUM_SAMPLES(8), .ADDR_W(3), .STG_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .issue_valid(issue_valid), .issue_rdy(issue_rdy),
        .addr_a(addr_a), .addr_b(addr_b), .twdl_addr(twdl_addr), .stage(stage),
        .wb_ack(wb_ack), .busy(busy), .done(done), .err_underflw(err_underflw),
        .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    int npass = 0, nchk = 0;
    int busy_cnt, done_cnt, iss_idx, skip_idx, n;
    logic ack_auto, ack_force, rdy_toggle, acc_s, hold_pend;
    logic [31:0] hold_val;
    int qa[$], qb[$], qt[$], qs[$];

`ifdef FFT_BFLY_SCHED_CYC_CNT_EN
    localparam int EXP_CYC = 16;
`else
    localparam int EXP_CYC = 0;
`endif

    int exp_a [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int exp_b [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    int exp_t [12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
    int exp_s [12] = '{0,0,0,0, 1,1,1,1, 2,2,2,2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_toggle) issue_rdy = ~issue_rdy;
    endtask

    task automatic clear_log();
        qa.delete(); qb.delete(); qt.delete(); qs.delete();
        busy_cnt = 0; done_cnt = 0; iss_idx = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        n = 1;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, qa.size(), 12);
        for (int i = 0; i < 12 && i < qa.size(); i++) begin
            chk($sformatf("%s_a%0d", tag, i), qa[i], exp_a[i]);
            chk($sformatf("%s_b%0d", tag, i), qb[i], exp_b[i]);
            chk($sformatf("%s_t%0d", tag, i), qt[i], exp_t[i]);
            chk($sformatf("%s_s%0d", tag, i), qs[i], exp_s[i]);
        end
    endtask

    // Write-back responder: one ack in the cycle after each accepted issue,
    // except the issue numbered skip_idx; ack_force injects extra acks.
    initial begin
        forever begin
            @(negedge clk);
            acc_s = issue_valid && issue_rdy;
            if (acc_s) begin
                if (iss_idx == skip_idx) acc_s = 1'b0;
                iss_idx++;
            end
            @(posedge clk);
            #2;
            wb_ack = (ack_auto && acc_s) || ack_force;
        end
    end

    // Monitor: logs accepted butterflies and checks that a stalled request holds.
    initial begin
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (hold_pend) begin
                chk("hold_valid", issue_valid, 1);
                chk("hold_addr", {addr_a, addr_b, twdl_addr}, hold_val);
            end
            hold_pend = issue_valid && !issue_rdy && !abort;
            hold_val  = {24'd0, addr_a, addr_b, twdl_addr};
            if (issue_valid && issue_rdy) begin
                qa.push_back(addr_a); qb.push_back(addr_b);
                qt.push_back(twdl_addr); qs.push_back(stage);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; issue_rdy = 1'b0; wb_ack = 1'b0;
        ack_auto = 1'b1; ack_force = 1'b0; rdy_toggle = 1'b0; skip_idx = -1;
        clear_log();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", issue_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", {addr_a, addr_b, twdl_addr, stage}, 0);
        chk("rst_err", err_underflw, 0);
        chk("rst_cyc", cyc_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: back-to-back issues, ack one cycle later
        issue_rdy = 1'b1;
        clear_log();
        pulse_start();
        chk("t1_first_valid", issue_valid, 1);
        run_to_done("t1_done");
        chk("t1_done_cycle", n, 16);
        start = 1'b1;                 // coincides with done: must be ignored
        tick();
        start = 1'b0;
        chk("t1_start_in_done_busy", busy, 0);
        tick(); tick();
        chk("t1_busy_cycles", busy_cnt, 16);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_cyc_cnt", cyc_cnt, EXP_CYC);
        chk("t1_err", err_underflw, 0);
        check_seq("t1");

        // Test 3: ready toggling every cycle
        clear_log();
        issue_rdy = 1'b0;
        rdy_toggle = 1'b1;
        pulse_start();
        run_to_done("t3_done");
        rdy_toggle = 1'b0;
        issue_rdy = 1'b1;
        tick(); tick();
        chk("t3_done_pulses", done_cnt, 1);
        check_seq("t3");

        // Test 4: last stage-0 write-back delayed
        clear_log();
        skip_idx = 3;
        pulse_start();
        n = 0;
        while (issue_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 9; i++) tick();
        chk("t4_drain_busy", busy, 1);
        chk("t4_drain_valid", issue_valid, 0);
        chk("t4_drain_stage", stage, 0);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("t4_resume_valid", issue_valid, 1);
        chk("t4_resume_stage", stage, 1);
        chk("t4_resume_pair", {addr_a, addr_b}, {3'd0, 3'd2});
        skip_idx = -1;
        run_to_done("t4_done");
        tick(); tick();
        chk("t4_done_pulses", done_cnt, 1);
        chk("t4_err", err_underflw, 0);
        check_seq("t4");

        // Test 5: abort during stage 1, k=2
        clear_log();
        pulse_start();
        n = 0;
        while (!(issue_valid && stage == 2'd1 && addr_a == 3'd4) && n < 40) begin
            tick();
            n++;
        end
        chk("t5_reach_k2", {issue_valid, stage, addr_a}, {1'b1, 2'd1, 3'd4});
        abort = 1'b1;
        issue_rdy = 1'b0;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_valid", issue_valid, 0);
        chk("t5_abort_stage", stage, 0);
        tick(); tick(); tick();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_err", err_underflw, 0);
        issue_rdy = 1'b1;
        pulse_start();
        chk("t5_restart", {issue_valid, stage, addr_a, addr_b}, {1'b1, 2'd0, 3'd0, 3'd1});
        run_to_done("t5_done");
        tick(); tick();
        chk("t5_done_pulses", done_cnt, 1);

        // Test 6: write-back ack while idle
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("t6_err_set", err_underflw, 1);
        tick(); tick(); tick();
        chk("t6_err_sticky", err_underflw, 1);
        pulse_start();
        chk("t6_err_cleared", err_underflw, 0);
        run_to_done("t6_done");
        tick();

        // Reset in the middle of a run
        pulse_start();
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", issue_valid, 0);
        chk("rst_mid_cyc", cyc_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
